tqv_peri_bridge: RTL and testbench
==================================

# tqv_peri_bridge

Bus bridge between the TinyQV core data port and a bank of full peripherals. Decodes the peripheral index from the core address, forwards one registered request at a time to the selected peripheral, and waits for that peripheral's `data_ready`. Returns read data to the core with size masking. Bounds every read with a timeout counter so that a dead peripheral cannot hang the core.

## Interface
Parameters:
- `NUM_PERIPH`, default 4: number of attached peripherals, 1..16.
- `TIMEOUT_CYCLES`, default 16: maximum read wait in ACCESS before forced completion, 1..255.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `core_addr`  in  10  bits [9:6] select the peripheral index; bits [5:0] are the offset.
- `core_data_in`  in  32  write data.
- `core_write_n`  in  2  write request: 11 none, 00 byte, 01 half, 10 word.
- `core_read_n`  in  2  read request, same encoding as `core_write_n`.
- `core_data_out`  out  32  read data, valid while `core_ready` is 1.
- `core_ready`  out  1  one-cycle completion pulse.
- `per_address`  out  6  registered offset, common to all peripherals.
- `per_data_in`  out  32  registered write data, common to all peripherals.
- `per_write_n`  out  2*NUM_PERIPH  per-peripheral write strobe; slice i is bits [2i+1:2i].
- `per_read_n`  out  2*NUM_PERIPH  per-peripheral read request, same slicing.
- `per_data_out`  in  32*NUM_PERIPH  per-peripheral read data; slice i is bits [32i+31:32i].
- `per_data_ready`  in  NUM_PERIPH  per-peripheral ready.
- `bus_error`  out  1  sticky timeout flag.
- `err_clr`  in  1  synchronous clear for `bus_error`.

## Operation
States: IDLE, ACCESS, RESP, DONE.
- **IDLE:** a request is present when `core_write_n` != 11 or `core_read_n` != 11.
  - If both are active, the write wins and the read is ignored.
  - On a request, latch index, offset, data, size and direction.
  - If index < NUM_PERIPH, go to ACCESS.
  - Otherwise go to RESP with read data 0 and no peripheral strobe.
- **ACCESS, write:**
  - Drive the latched size on the selected `per_write_n` slice for exactly this cycle.
  - `core_ready`=1 in the same cycle, then go to DONE.
  - `per_data_ready` is not consulted for writes.
- **ACCESS, read:**
  - Hold the latched size on the selected `per_read_n` slice while in ACCESS.
  - When `per_data_ready[sel]`=1, register `per_data_out` slice sel with size masking (byte: [31:8]=0; half: [31:16]=0; word: unmasked), then go to RESP.
  - Timeout counter (width clog2(TIMEOUT_CYCLES+1)) clears on entry to ACCESS and increments each ACCESS cycle without ready.
  - When the counter reaches TIMEOUT_CYCLES, read data is forced to 0, `bus_error` is set, and the state goes to RESP.
  - If ready and timeout occur in the same cycle, ready wins and there is no error.
- **RESP:** `core_ready`=1 and `core_data_out` valid for one cycle, then go to DONE.
- **DONE:** request lines are ignored for one cycle (the core removes its request in this window), then go to IDLE.
- **Strobe outputs:** unselected peripheral slices are always 11. All slices are 11 outside ACCESS.
- **`bus_error`:**
  - Set on timeout.
  - Cleared when `err_clr`=1.
  - If set and clear coincide, set wins.
- **Reset (at any point, including mid-ACCESS):**
  - State goes to IDLE; all strobes 11; `core_ready`=0; `core_data_out`=0; `per_address`=0; `per_data_in`=0; `bus_error`=0; counter=0.
  - No completion is issued for the aborted request.

## Timing
- Write: request seen at edge N. ACCESS (strobe + `core_ready`) during cycle N+1. DONE N+2. IDLE N+3.
- Read with peripheral ready combinationally in the first ACCESS cycle: ACCESS N+1, RESP (`core_ready`) N+2, i.e. 2-cycle latency. Each wait cycle adds 1.
- Read timeout: `core_ready` occurs TIMEOUT_CYCLES+1 cycles after the first ACCESS cycle.
- Out-of-range index: `core_ready` in cycle N+1.
- Maximum throughput: one request every 3 cycles (write) or every 4 cycles (read, zero wait).
- `per_address`/`per_data_in` are stable from ACCESS entry until the next IDLE capture.

## Test plan
- Word write of 0xDEADBEEF to addr 0x085 (peripheral 2, offset 5) -> `per_write_n[5:4]`=10 for one cycle, `per_address`=5, `per_data_in`=0xDEADBEEF, `core_ready` in the same cycle, all other slices 11.
- Byte read from peripheral 1, which returns 0x12345678 with ready after 3 wait cycles -> `core_data_out`=0x00000078, `core_ready` 5 cycles after the request edge, `bus_error`=0.
- Read from peripheral 0 with ready stuck at 0, TIMEOUT_CYCLES=16 -> `core_ready` with data 0 after 17 ACCESS-entry cycles, `bus_error`=1; an `err_clr` pulse clears it.
- Read at index 7 with NUM_PERIPH=4 -> no strobe on any slice, `core_ready` next cycle, data 0, no error.
- Read and write asserted together to peripheral 3 -> only the write strobe is driven, no read strobe.
- `rst_n` low during a pending read in ACCESS -> all outputs take their reset values immediately; after release, a new request completes normally.

Source files
------------

// File: rtl/tqv_peri_bridge.sv
// Bridge from the TinyQV core data port to a bank of peripherals: one registered
// request at a time, size-masked read return, and a timeout bounding every read.
module tqv_peri_bridge #(
  parameter int NUM_PERIPH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [9:0]              core_addr,
  input  logic [31:0]             core_data_in,
  input  logic [1:0]              core_write_n,
  input  logic [1:0]              core_read_n,
  output logic [31:0]             core_data_out,
  output logic                    core_ready,
  output logic [5:0]              per_address,
  output logic [31:0]             per_data_in,
  output logic [2*NUM_PERIPH-1:0] per_write_n,
  output logic [2*NUM_PERIPH-1:0] per_read_n,
  input  logic [32*NUM_PERIPH-1:0] per_data_out,
  input  logic [NUM_PERIPH-1:0]   per_data_ready,
  output logic                    bus_error,
  input  logic                    err_clr
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [4:0] NP = 5'(NUM_PERIPH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, DONE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    sel;
  logic [1:0]    size;
  logic          is_write;
  logic [CW-1:0] tmo_cnt;
  logic [31:0]   sel_data;
  logic [31:0]   masked_data;
  logic          sel_ready;
  logic          req_wr, req_rd, req, in_range, timeout;

  assign req_wr   = (core_write_n != 2'b11);
  assign req_rd   = (core_read_n != 2'b11);
  assign req      = req_wr || req_rd;
  assign in_range = ({1'b0, core_addr[9:6]} < NP);
  assign timeout  = (state == ACCESS) && !is_write && !sel_ready && (tmo_cnt == TMO_LIMIT);

  // Selected peripheral's read data and ready, plus size masking of that data
  always_comb begin
    sel_data  = '0;
    sel_ready = 1'b0;
    for (int i = 0; i < NUM_PERIPH; i++) begin
      if (sel == 4'(i)) begin
        sel_data  = per_data_out[32*i +: 32];
        sel_ready = per_data_ready[i];
      end
    end
    case (size)
      2'b00:   masked_data = {24'h0, sel_data[7:0]};
      2'b01:   masked_data = {16'h0, sel_data[15:0]};
      default: masked_data = sel_data;
    endcase
  end

  always_comb begin
    per_write_n = '1;
    per_read_n  = '1;
    if (state == ACCESS) begin
      for (int i = 0; i < NUM_PERIPH; i++) begin
        if (sel == 4'(i)) begin
          if (is_write) per_write_n[2*i +: 2] = size;
          else          per_read_n[2*i +: 2]  = size;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    core_ready = 1'b0;
    case (state)
      IDLE: begin
        if (req) state_nxt = in_range ? ACCESS : RESP;
      end
      ACCESS: begin
        if (is_write) begin
          core_ready = 1'b1;
          state_nxt  = DONE;
        end else if (sel_ready || timeout) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        core_ready = 1'b1;
        state_nxt  = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, read return and timeout counting; the counter is
  // cleared in IDLE so every ACCESS entry starts from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel           <= '0;
      size          <= 2'b11;
      is_write      <= 1'b0;
      per_address   <= '0;
      per_data_in   <= '0;
      core_data_out <= '0;
      tmo_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (req) begin
            sel           <= core_addr[9:6];
            per_address   <= core_addr[5:0];
            per_data_in   <= core_data_in;
            is_write      <= req_wr;
            size          <= req_wr ? core_write_n : core_read_n;
            core_data_out <= '0;
          end
        end
        ACCESS: begin
          if (!is_write) begin
            if (sel_ready)    core_data_out <= masked_data;
            else if (timeout) core_data_out <= '0;
            else              tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       bus_error <= 1'b0;
    else if (timeout) bus_error <= 1'b1;
    else if (err_clr) bus_error <= 1'b0;
  end

endmodule

// File: tb/tb_tqv_peri_bridge.sv
// Directed bench for tqv_peri_bridge with NUM_PERIPH=4, TIMEOUT_CYCLES=16.
module tb_tqv_peri_bridge;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [9:0]    core_addr;
  logic [31:0]   core_data_in;
  logic [1:0]    core_write_n;
  logic [1:0]    core_read_n;
  logic [31:0]   core_data_out;
  logic          core_ready;
  logic [5:0]    per_address;
  logic [31:0]   per_data_in;
  logic [7:0]    per_write_n;
  logic [7:0]    per_read_n;
  logic [127:0]  per_data_out;
  logic [3:0]    per_data_ready;
  logic          bus_error;
  logic          err_clr;

  int testCount = 0;
  int failCount = 0;

  tqv_peri_bridge #(.NUM_PERIPH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_addr(core_addr), .core_data_in(core_data_in),
    .core_write_n(core_write_n), .core_read_n(core_read_n),
    .core_data_out(core_data_out), .core_ready(core_ready),
    .per_address(per_address), .per_data_in(per_data_in),
    .per_write_n(per_write_n), .per_read_n(per_read_n),
    .per_data_out(per_data_out), .per_data_ready(per_data_ready),
    .bus_error(bus_error), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [9:0] addr, input logic [31:0] data,
                               input logic [1:0] wr_n, input logic [1:0] rd_n);
    core_addr    = addr;
    core_data_in = data;
    core_write_n = wr_n;
    core_read_n  = rd_n;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    err_clr        = 1'b0;
    per_data_ready = 4'b0000;
    per_data_out   = {32'h44444444, 32'h33333333, 32'h12345678, 32'h11111111};
    applyStimulus(10'h000, 32'h0, 2'b11, 2'b11);
    tick; tick;

    checkOutput("rst_ready",   32'(core_ready), 32'h0);
    checkOutput("rst_data",    core_data_out, 32'h0);
    checkOutput("rst_addr",    32'(per_address), 32'h0);
    checkOutput("rst_wdata",   per_data_in, 32'h0);
    checkOutput("rst_write_n", 32'(per_write_n), 32'hFF);
    checkOutput("rst_read_n",  32'(per_read_n), 32'hFF);
    checkOutput("rst_err",     32'(bus_error), 32'h0);
    rst_n = 1'b1;
    tick;

    // Word write to peripheral 2 offset 5
    applyStimulus(10'h085, 32'hDEADBEEF, 2'b10, 2'b11);
    tick;
    applyStimulus(10'h000, 32'h0, 2'b11, 2'b11);
    checkOutput("wr_write_n", 32'(per_write_n), 32'hEF);
    checkOutput("wr_read_n",  32'(per_read_n), 32'hFF);
    checkOutput("wr_addr",    32'(per_address), 32'h5);
    checkOutput("wr_wdata",   per_data_in, 32'hDEADBEEF);
    checkOutput("wr_ready",   32'(core_ready), 32'h1);
    tick;
    checkOutput("wr_done_ready",   32'(core_ready), 32'h0);
    checkOutput("wr_done_write_n", 32'(per_write_n), 32'hFF);
    checkOutput("wr_done_addr",    32'(per_address), 32'h5);
    tick;

    // Byte read from peripheral 1, ready after three wait cycles
    applyStimulus(10'h04C, 32'h0, 2'b11, 2'b00);
    tick;
    applyStimulus(10'h000, 32'h0, 2'b11, 2'b11);
    checkOutput("rdb_read_n", 32'(per_read_n), 32'hF3);
    checkOutput("rdb_wait1",  32'(core_ready), 32'h0);
    tick;
    checkOutput("rdb_wait2",  32'(core_ready), 32'h0);
    tick;
    checkOutput("rdb_wait3",  32'(core_ready), 32'h0);
    tick;
    per_data_ready = 4'b0010;
    #1;
    checkOutput("rdb_readycyc", 32'(core_ready), 32'h0);
    tick;
    per_data_ready = 4'b0000;
    checkOutput("rdb_ready",  32'(core_ready), 32'h1);
    checkOutput("rdb_data",   core_data_out, 32'h00000078);
    checkOutput("rdb_err",    32'(bus_error), 32'h0);
    checkOutput("rdb_resp_read_n", 32'(per_read_n), 32'hFF);
    tick;
    checkOutput("rdb_done_ready", 32'(core_ready), 32'h0);
    tick;

    // Word read from peripheral 0 that never answers
    applyStimulus(10'h003, 32'h0, 2'b11, 2'b10);
    tick;
    applyStimulus(10'h000, 32'h0, 2'b11, 2'b11);
    checkOutput("tmo_read_n", 32'(per_read_n), 32'hFE);
    for (int k = 0; k < 17; k++) begin
      checkOutput($sformatf("tmo_wait%0d", k), 32'(core_ready), 32'h0);
      if (k < 16) tick;
    end
    checkOutput("tmo_err_before", 32'(bus_error), 32'h0);
    tick;
    checkOutput("tmo_ready", 32'(core_ready), 32'h1);
    checkOutput("tmo_data",  core_data_out, 32'h0);
    checkOutput("tmo_err",   32'(bus_error), 32'h1);
    tick;
    checkOutput("tmo_err_sticky", 32'(bus_error), 32'h1);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    checkOutput("tmo_err_clr", 32'(bus_error), 32'h0);

    // Out-of-range index 7
    applyStimulus(10'h1C0, 32'h0, 2'b11, 2'b01);
    tick;
    applyStimulus(10'h000, 32'h0, 2'b11, 2'b11);
    checkOutput("oor_ready",   32'(core_ready), 32'h1);
    checkOutput("oor_data",    core_data_out, 32'h0);
    checkOutput("oor_read_n",  32'(per_read_n), 32'hFF);
    checkOutput("oor_write_n", 32'(per_write_n), 32'hFF);
    checkOutput("oor_err",     32'(bus_error), 32'h0);
    tick;
    checkOutput("oor_done_ready", 32'(core_ready), 32'h0);
    tick;

    // Simultaneous half write and byte read to peripheral 3
    applyStimulus(10'h0C2, 32'h0000A5A5, 2'b01, 2'b00);
    tick;
    applyStimulus(10'h000, 32'h0, 2'b11, 2'b11);
    checkOutput("both_write_n", 32'(per_write_n), 32'h7F);
    checkOutput("both_read_n",  32'(per_read_n), 32'hFF);
    checkOutput("both_ready",   32'(core_ready), 32'h1);
    checkOutput("both_wdata",   per_data_in, 32'h0000A5A5);
    tick; tick;

    // Reset asserted while a read to peripheral 2 waits in ACCESS
    applyStimulus(10'h0A0, 32'h0BADF00D, 2'b11, 2'b10);
    tick;
    applyStimulus(10'h000, 32'h0, 2'b11, 2'b11);
    checkOutput("ra_read_n", 32'(per_read_n), 32'hEF);
    checkOutput("ra_addr",   32'(per_address), 32'h20);
    rst_n = 1'b0;
    #1;
    checkOutput("ra_rst_read_n", 32'(per_read_n), 32'hFF);
    checkOutput("ra_rst_ready",  32'(core_ready), 32'h0);
    checkOutput("ra_rst_addr",   32'(per_address), 32'h0);
    checkOutput("ra_rst_wdata",  per_data_in, 32'h0);
    checkOutput("ra_rst_data",   core_data_out, 32'h0);
    checkOutput("ra_rst_err",    32'(bus_error), 32'h0);
    tick;
    checkOutput("ra_rst_hold_ready", 32'(core_ready), 32'h0);
    rst_n = 1'b1;
    tick;
    checkOutput("ra_idle_ready", 32'(core_ready), 32'h0);

    // Half read from peripheral 2 with ready in the first ACCESS cycle
    per_data_out[95:64] = 32'hCAFEF00D;
    per_data_ready      = 4'b0100;
    applyStimulus(10'h0A4, 32'h0, 2'b11, 2'b01);
    tick;
    applyStimulus(10'h000, 32'h0, 2'b11, 2'b11);
    checkOutput("rh_read_n", 32'(per_read_n), 32'hDF);
    checkOutput("rh_access_ready", 32'(core_ready), 32'h0);
    tick;
    per_data_ready = 4'b0000;
    checkOutput("rh_ready", 32'(core_ready), 32'h1);
    checkOutput("rh_data",  core_data_out, 32'h0000F00D);
    checkOutput("rh_addr",  32'(per_address), 32'h24);
    tick;
    checkOutput("rh_done_ready", 32'(core_ready), 32'h0);
    tick;

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
